// File: rtl/multi_debouncer_pkg.sv
// Shared definitions for the input-conditioning blocks: counter width helper,
// button polarity constants and the per-channel filter state type.
package multi_debouncer_pkg;

   // Reset level for buttons that idle low (pressed = 1).
   localparam logic BTN_ACTIVE_HIGH = 1'b0;
   // Reset level for buttons that idle high (pressed = 0).
   localparam logic BTN_ACTIVE_LOW  = 1'b1;

   // Filter state of one channel: IDLE while the synchronised input agrees
   // with the filtered level, COUNTING while it disagrees.
   typedef enum logic {
      CH_IDLE     = 1'b0,
      CH_COUNTING = 1'b1
   } ch_state_t;

   // Ceiling log2; returns the bit count needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int r;
      for (r = 0; (1 << r) < value; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: 2-flop synchroniser, stability counter, filtered level
// flop and registered one-cycle rise/fall pulses.
module debounce_channel
   import multi_debouncer_pkg::*;
#(
   parameter int   STABLE_CYCLES = 500000,
   parameter logic RESET_LEVEL   = BTN_ACTIVE_HIGH
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_filt,
   output logic o_rise,
   output logic o_fall
);

   localparam int CNT_W = clog2(STABLE_CYCLES + 1);
   // Counter value on the edge where the filtered level is allowed to follow.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_filt;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;
   ch_state_t        w_state;

   // The state is implied by the comparison; only sync2 ever reaches the filter.
   assign w_state = (r_sync2 == r_filt) ? CH_IDLE : CH_COUNTING;

   // Synchronise, then require STABLE_CYCLES consecutive mismatches before following.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= RESET_LEVEL;
         r_sync2 <= RESET_LEVEL;
         r_filt  <= RESET_LEVEL;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         case (w_state)
            CH_IDLE: begin
               // Any agreement, even for a single cycle, restarts qualification.
               r_cnt <= '0;
            end
            CH_COUNTING: begin
               if (r_cnt == LAST_CNT) begin
                  r_filt <= r_sync2;
                  r_cnt  <= '0;
                  r_rise <= r_sync2;
                  r_fall <= ~r_sync2;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign o_filt = r_filt;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/multi_debouncer.sv
// N independent debounce channels with per-channel edge pulses and an
// any-change flag, so downstream FSMs need no edge detectors of their own.
module multi_debouncer
   import multi_debouncer_pkg::*;
#(
   parameter int   CHANNELS      = 4,
   parameter int   STABLE_CYCLES = 500000,
   parameter logic RESET_LEVEL   = BTN_ACTIVE_HIGH
) (
   input  logic                i_CLOCK_SOURCE,
   input  logic                i_RESET,
   input  logic [CHANNELS-1:0] i_NOISE_SIGNAL,
   output logic [CHANNELS-1:0] o_FILTER_SIGNAL,
   output logic [CHANNELS-1:0] o_RISE_PULSE,
   output logic [CHANNELS-1:0] o_FALL_PULSE,
   output logic                o_ANY_CHANGE
);

   logic [CHANNELS-1:0] w_edge;

   // One filter per input bit; channels share nothing but clock and reset.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .RESET_LEVEL   (RESET_LEVEL)
      ) u_ch (
         .i_clk  (i_CLOCK_SOURCE),
         .i_rst  (i_RESET),
         .i_raw  (i_NOISE_SIGNAL[g]),
         .o_filt (o_FILTER_SIGNAL[g]),
         .o_rise (o_RISE_PULSE[g]),
         .o_fall (o_FALL_PULSE[g])
      );
   end

   // Pulses are already registered, so the OR stays off the raw input path.
   assign w_edge       = o_RISE_PULSE | o_FALL_PULSE;
   assign o_ANY_CHANGE = |w_edge;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios with hand-derived timing plus
// a randomized run compared against a sliding-window reference model.
module tb_multi_debouncer;

   localparam int S = 4;

   logic       clk;
   logic       rst;
   logic [3:0] noise;
   logic [3:0] filt, rise, fall;
   logic       any;
   logic [3:0] noise_al;
   logic [3:0] filt_al, rise_al, fall_al;
   logic       any_al;

   int n_vec;
   int n_miss;

   multi_debouncer #(.CHANNELS(4), .STABLE_CYCLES(S), .RESET_LEVEL(1'b0)) dut (
      .i_CLOCK_SOURCE  (clk),
      .i_RESET         (rst),
      .i_NOISE_SIGNAL  (noise),
      .o_FILTER_SIGNAL (filt),
      .o_RISE_PULSE    (rise),
      .o_FALL_PULSE    (fall),
      .o_ANY_CHANGE    (any)
   );

   multi_debouncer #(.CHANNELS(4), .STABLE_CYCLES(1), .RESET_LEVEL(1'b1)) dut_al (
      .i_CLOCK_SOURCE  (clk),
      .i_RESET         (rst),
      .i_NOISE_SIGNAL  (noise_al),
      .o_FILTER_SIGNAL (filt_al),
      .o_RISE_PULSE    (rise_al),
      .o_FALL_PULSE    (fall_al),
      .o_ANY_CHANGE    (any_al)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // The filtered bit flips at an edge exactly when the raw samples taken
   // S+1 .. 2 edges earlier all differ from the current filtered bit.
   logic [3:0] m_hist[$];
   logic [3:0] m_filt, m_rise, m_fall;

   always @(posedge clk or posedge rst) begin : model
      automatic logic [3:0] f, r, d;
      automatic logic       all_diff;
      if (rst) begin
         m_hist.delete();
         for (int i = 0; i < S + 2; i++) m_hist.push_back(4'b0000);
         m_filt <= 4'b0000;
         m_rise <= 4'b0000;
         m_fall <= 4'b0000;
      end else begin
         m_hist.push_back(noise);
         if (m_hist.size() > S + 2) void'(m_hist.pop_front());
         f = m_filt;
         r = 4'b0000;
         d = 4'b0000;
         for (int ch = 0; ch < 4; ch++) begin
            all_diff = 1'b1;
            for (int k = 0; k < S; k++)
               if (m_hist[k][ch] == m_filt[ch]) all_diff = 1'b0;
            if (all_diff) begin
               f[ch] = ~m_filt[ch];
               r[ch] = ~m_filt[ch];
               d[ch] = m_filt[ch];
            end
         end
         m_filt <= f;
         m_rise <= r;
         m_fall <= d;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      noise    = 4'b0000;
      noise_al = 4'b1111;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst      = 1'b1;
      noise    = 4'b0000;
      noise_al = 4'b1111;
      repeat (2) @(negedge clk);
      n_vec++;
      if (filt !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || any !== 1'b0) begin
         $display("FAIL reset_hi: filt=%b rise=%b fall=%b any=%b expected 0000 0000 0000 0", filt, rise, fall, any);
         n_miss++;
      end
      n_vec++;
      if (filt_al !== 4'b1111 || rise_al !== 4'b0000 || fall_al !== 4'b0000 || any_al !== 1'b0) begin
         $display("FAIL reset_lo: filt=%b rise=%b fall=%b any=%b expected 1111 0000 0000 0", filt_al, rise_al, fall_al, any_al);
         n_miss++;
      end
      rst = 1'b0;
   endtask

   task automatic test_clean_press();
      logic [3:0] ef, er;
      do_reset();
      noise = 4'b0001;
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         ef = (e >= 5) ? 4'b0001 : 4'b0000;
         er = (e == 5) ? 4'b0001 : 4'b0000;
         n_vec++;
         if (filt !== ef || rise !== er || fall !== 4'b0000 || any !== (e == 5)) begin
            $display("FAIL clean_press e%0d: filt=%b rise=%b fall=%b any=%b expected %b %b 0000 %b", e, filt, rise, fall, any, ef, er, (e == 5));
            n_miss++;
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] ef, er;
      do_reset();
      for (int e = 0; e < 14; e++) begin
         noise[1] = (e < 8) ? ~e[0] : 1'b0;
         @(negedge clk);
         n_vec++;
         if (filt !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || any !== 1'b0) begin
            $display("FAIL bounce e%0d: filt=%b rise=%b fall=%b any=%b expected all zero", e, filt, rise, fall, any);
            n_miss++;
         end
      end
      // Counter must have restarted from zero: a clean press needs the full latency.
      noise[1] = 1'b1;
      for (int e = 0; e < 8; e++) begin
         @(negedge clk);
         ef = (e >= 5) ? 4'b0010 : 4'b0000;
         er = (e == 5) ? 4'b0010 : 4'b0000;
         n_vec++;
         if (filt !== ef || rise !== er || any !== (e == 5)) begin
            $display("FAIL bounce_after e%0d: filt=%b rise=%b any=%b expected %b %b %b", e, filt, rise, any, ef, er, (e == 5));
            n_miss++;
         end
      end
   endtask

   task automatic test_min_width();
      logic [3:0] ef, er, ed;
      do_reset();
      noise[2] = 1'b1;
      for (int e = 0; e < 12; e++) begin
         @(negedge clk);
         if (e == 2) noise[2] = 1'b0;
         n_vec++;
         if (filt !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || any !== 1'b0) begin
            $display("FAIL short3 e%0d: filt=%b rise=%b fall=%b any=%b expected all zero", e, filt, rise, fall, any);
            n_miss++;
         end
      end
      noise[2] = 1'b1;
      for (int e = 0; e < 16; e++) begin
         @(negedge clk);
         if (e == 5) noise[2] = 1'b0;
         ef = (e >= 5 && e < 11) ? 4'b0100 : 4'b0000;
         er = (e == 5) ? 4'b0100 : 4'b0000;
         ed = (e == 11) ? 4'b0100 : 4'b0000;
         n_vec++;
         if (filt !== ef || rise !== er || fall !== ed || any !== (e == 5 || e == 11)) begin
            $display("FAIL wide6 e%0d: filt=%b rise=%b fall=%b any=%b expected %b %b %b %b", e, filt, rise, fall, any, ef, er, ed, (e == 5 || e == 11));
            n_miss++;
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] ef, er;
      do_reset();
      noise = 4'b1001;
      for (int e = 0; e < 9; e++) begin
         @(negedge clk);
         ef = (e >= 5) ? 4'b1001 : 4'b0000;
         er = (e == 5) ? 4'b1001 : 4'b0000;
         n_vec++;
         if (filt !== ef || rise !== er || fall !== 4'b0000 || any !== (e == 5)) begin
            $display("FAIL simult e%0d: filt=%b rise=%b fall=%b any=%b expected %b %b 0000 %b", e, filt, rise, fall, any, ef, er, (e == 5));
            n_miss++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] ef, er;
      do_reset();
      noise = 4'b1000;
      @(negedge clk);            // edge 0 sampled
      @(negedge clk);            // edge 1 sampled
      noise[0] = 1'b1;           // bit0 first sampled at edge 2
      repeat (4) @(posedge clk); // edges 2..5; bit3 rises at edge 5
      #2;
      n_vec++;
      if (filt !== 4'b1000 || rise !== 4'b1000) begin
         $display("FAIL premid: filt=%b rise=%b expected 1000 1000", filt, rise);
         n_miss++;
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (filt !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || any !== 1'b0) begin
         $display("FAIL async_rst: filt=%b rise=%b fall=%b any=%b expected all zero", filt, rise, fall, any);
         n_miss++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int e = 0; e < 12; e++) begin
         @(negedge clk);
         ef = (e >= 5) ? 4'b1001 : 4'b0000;
         er = (e == 5) ? 4'b1001 : 4'b0000;
         n_vec++;
         if (filt !== ef || rise !== er || fall !== 4'b0000 || any !== (e == 5)) begin
            $display("FAIL post_rst e%0d: filt=%b rise=%b fall=%b any=%b expected %b %b 0000 %b", e, filt, rise, fall, any, ef, er, (e == 5));
            n_miss++;
         end
      end
   endtask

   task automatic test_active_low();
      logic [3:0] ef, ed;
      do_reset();
      noise_al[2] = 1'b0;
      for (int e = 0; e < 6; e++) begin
         @(negedge clk);
         ef = (e >= 2) ? 4'b1011 : 4'b1111;
         ed = (e == 2) ? 4'b0100 : 4'b0000;
         n_vec++;
         if (filt_al !== ef || fall_al !== ed || rise_al !== 4'b0000 || any_al !== (e == 2)) begin
            $display("FAIL active_low e%0d: filt=%b rise=%b fall=%b any=%b expected %b 0000 %b %b", e, filt_al, rise_al, fall_al, any_al, ef, ed, (e == 2));
            n_miss++;
         end
      end
   endtask

   task automatic test_random();
      int dur[4];
      do_reset();
      for (int ch = 0; ch < 4; ch++) dur[ch] = $urandom_range(1, 7);
      for (int c = 0; c < 600; c++) begin
         for (int ch = 0; ch < 4; ch++) begin
            dur[ch]--;
            if (dur[ch] == 0) begin
               noise[ch] = ~noise[ch];
               dur[ch]   = $urandom_range(1, 7);
            end
         end
         @(negedge clk);
         n_vec++;
         if (filt !== m_filt || rise !== m_rise || fall !== m_fall || any !== |(m_rise | m_fall)) begin
            $display("FAIL random c%0d: filt=%b rise=%b fall=%b any=%b expected %b %b %b %b", c, filt, rise, fall, any, m_filt, m_rise, m_fall, |(m_rise | m_fall));
            n_miss++;
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_vec    = 0;
      n_miss   = 0;
      rst      = 1'b1;
      noise    = 4'b0000;
      noise_al = 4'b1111;
      test_reset();
      test_clean_press();
      test_bounce();
      test_min_width();
      test_simultaneous();
      test_reset_mid();
      test_active_low();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised N-channel successor to the single-button filter.
- Each channel has its own 2-flop synchroniser, its own stability counter and a programmable threshold.
- Per channel it produces a filtered level plus one-cycle rise and fall pulses; an any-change flag is OR-ed across channels.
- Sits between raw board buttons/switches and control FSMs, so that downstream logic needs no edge detectors of its own.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1)
- STABLE_CYCLES, 500000, consecutive clocks a synchronised input must differ from the filtered output before the output follows (>=1)
- RESET_LEVEL, 1'b0, value loaded into synchronisers and filtered outputs on reset (1'b1 for active-low buttons)
- CNT_W, derived, $clog2(STABLE_CYCLES+1); localparam, not user-set

Ports:
- i_CLOCK_SOURCE  input  1  single clock; all state updates on its rising edge
- i_RESET  input  1  asynchronous, active-high reset
- i_NOISE_SIGNAL  input  CHANNELS  raw asynchronous inputs, bit n = channel n
- o_FILTER_SIGNAL  output  CHANNELS  debounced level per channel
- o_RISE_PULSE  output  CHANNELS  1-cycle high when filtered bit goes 0->1
- o_FALL_PULSE  output  CHANNELS  1-cycle high when filtered bit goes 1->0
- o_ANY_CHANGE  output  1  OR of all rise and fall pulses, same cycle

Behaviour:
- Reset (async assert, released synchronously by the clock):
  - sync1 = sync2 = RESET_LEVEL on all bits
  - o_FILTER_SIGNAL = {CHANNELS{RESET_LEVEL}}
  - all counters = 0
  - o_RISE_PULSE = o_FALL_PULSE = 0, o_ANY_CHANGE = 0
- Per-channel synchroniser: sync1 <= raw; sync2 <= sync1. Only sync2 feeds the filter.
- Per-channel filter, each edge, two states per channel (IDLE: sync2 == filt; COUNTING: sync2 != filt):
  - sync2 == filt: counter <= 0, no pulse.
  - sync2 != filt and counter < STABLE_CYCLES-1: counter <= counter+1.
  - sync2 != filt and counter == STABLE_CYCLES-1: filt <= sync2; counter <= 0; matching rise/fall pulse asserted for exactly this one following cycle.
- Any single-cycle return of sync2 to filt clears the counter, so a glitch shorter than STABLE_CYCLES is never propagated.
- Latency: raw change first sampled by sync1 at edge k produces the filtered update at edge k+1+STABLE_CYCLES, provided raw is stable throughout. Pulses are registered and aligned with the filtered update.
- STABLE_CYCLES=1: output follows sync2 one edge after the mismatch is first seen.
- Counter never exceeds STABLE_CYCLES-1; no wrap is possible.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses; o_ANY_CHANGE is high once for that cycle.
- Pulses on one channel cannot both be high; back-to-back pulses on a channel need at least STABLE_CYCLES clocks between them.
- Reset mid-count: everything returns to reset values immediately. A raw level differing from RESET_LEVEL is re-qualified from zero after release (full latency again, then one pulse).
- All outputs are registered; no combinational path from i_NOISE_SIGNAL to any output.

Decomposition:
- Shared package/header: the clog2 width helper and the RESET_LEVEL polarity constants (BTN_ACTIVE_HIGH=1'b0, BTN_ACTIVE_LOW=1'b1), reused by other input-conditioning blocks.
- One natural sub-module, debounce_channel:
  - one bit: synchroniser, counter, filtered flop, rise/fall pulse flops
  - parameters STABLE_CYCLES and RESET_LEVEL
- multi_debouncer instantiates CHANNELS copies in a generate loop and ORs the pulses into o_ANY_CHANGE.

Test Plan:
- Clean press: CHANNELS=4, STABLE_CYCLES=4, RESET_LEVEL=0; after reset set bit0=1 before edge 0 and hold -> o_FILTER_SIGNAL[0] rises at edge 5; o_RISE_PULSE[0] and o_ANY_CHANGE high for that cycle only; other bits stay 0.
- Bounce rejection: STABLE_CYCLES=4; bit1 toggles 1,0,1,0 each clock for 8 clocks, then holds 0 -> no output change, no pulses, counter back to 0.
- Minimum-width pulse: STABLE_CYCLES=4; bit2 high for exactly 3 clocks -> no change. Repeat with high for 6 clocks -> rise at edge 5 after first sample, then fall with o_FALL_PULSE[2] 5 edges after the drop is first sampled.
- Simultaneous channels: bits 0 and 3 go high on the same edge -> both filtered bits and both rise pulses assert in the same cycle; o_ANY_CHANGE high for one cycle.
- Reset mid-count: bit0 held high, i_RESET asserted asynchronously after 2 clocks of counting (between edges) -> outputs zero immediately. After release with bit0 still high -> rise at edge 5 relative to the first post-reset edge, exactly one rise pulse.
- Active-low instance: RESET_LEVEL=1, STABLE_CYCLES=1 -> reset drives o_FILTER_SIGNAL=4'hF; bit2 driven 0 -> fall at edge 2, one o_FALL_PULSE[2].
